// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port main_memory arbiter: FSM state encoding,
// requester port indices and a port-to-one-hot helper.
package mem_port_arbiter_pkg;

  localparam int MARB_STATE_WIDTH = 2;

  typedef enum logic [MARB_STATE_WIDTH-1:0] {
    MARB_IDLE   = 2'd0,
    MARB_ACCESS = 2'd1,
    MARB_RESP   = 2'd2
  } marb_state_e;

  localparam logic MARB_PORT_FETCH = 1'b0;
  localparam logic MARB_PORT_DATA  = 1'b1;

  function automatic logic [1:0] marb_port_onehot(input logic port);
    marb_port_onehot = (port == MARB_PORT_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake and main_memory bus of the arbiter; slave is the arbiter
// side, master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata1, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_raddr, mem_waddr, mem_wdata,
           mem_wen, busy
  );

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata1, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_raddr, mem_waddr, mem_wdata,
           mem_wen, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way grant: a lone requester always wins; on a tie the port
// that did not win last time wins (round-robin) or the data port wins (fixed).
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_port
);

  // Winner selection from the current request vector.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = MARB_PORT_FETCH;
    case (req_valid)
      2'b01: begin
        grant_valid = 1'b1;
        grant_port  = MARB_PORT_FETCH;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_port  = MARB_PORT_DATA;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_port  = RR_EN ? ~last_grant : MARB_PORT_DATA;
      end
      default: begin
        grant_valid = 1'b0;
        grant_port  = MARB_PORT_FETCH;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares single-ported main_memory between fetch (port 0) and data (port 1):
// accept in IDLE, read in ACCESS, one-cycle response pulse in RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  marb_state_e       state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              grant_valid_s;
  logic              grant_port_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [1:0]        req_ready_s;
  logic [ADDR_W-1:0] mem_raddr_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              mem_wen_s;

  rr_arbiter2 #(
    .RR_EN (RR_EN)
  ) u_rr_arbiter2 (
    .req_valid   (bus.req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid_s),
    .grant_port  (grant_port_s)
  );

  // Request fields of the arbitration winner; the fetch port never carries data.
  always_comb begin
    if (grant_port_s == MARB_PORT_DATA) begin
      sel_addr_s  = bus.req_addr1;
      sel_wdata_s = bus.req_wdata1;
    end else begin
      sel_addr_s  = bus.req_addr0;
      sel_wdata_s = {DATA_W{1'b0}};
    end
    sel_we_s = bus.req_we[grant_port_s];
  end

  // Next state, holding registers and memory drive for the current state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    rsp_valid_d  = 2'b00;
    rsp_data_d   = rsp_data_q;
    req_ready_s  = 2'b00;
    mem_raddr_s  = {ADDR_W{1'b0}};
    mem_waddr_s  = {ADDR_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    mem_wen_s    = 1'b0;
    case (state_q)
      MARB_IDLE: begin
        if (grant_valid_s) begin
          req_ready_s  = marb_port_onehot(grant_port_s);
          port_d       = grant_port_s;
          we_d         = sel_we_s;
          addr_d       = sel_addr_s;
          last_grant_d = grant_port_s;
          state_d      = MARB_ACCESS;
          // Writes go straight to memory in the accept cycle; reads start here.
          if (sel_we_s) begin
            mem_wen_s   = 1'b1;
            mem_waddr_s = sel_addr_s;
            mem_wdata_s = sel_wdata_s;
          end else begin
            mem_raddr_s = sel_addr_s;
          end
        end else begin
          state_d = MARB_IDLE;
        end
      end
      MARB_ACCESS: begin
        mem_raddr_s = addr_q;
        if (we_q) begin
          rsp_data_d = {DATA_W{1'b0}};
        end else begin
          rsp_data_d = bus.mem_rdata;
        end
        rsp_valid_d = marb_port_onehot(port_q);
        state_d     = MARB_RESP;
      end
      MARB_RESP: begin
        state_d = MARB_IDLE;
      end
      default: begin
        state_d = MARB_IDLE;
      end
    endcase
  end

  // FSM and holding registers; reset abandons an in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MARB_IDLE;
      last_grant_q <= MARB_PORT_DATA;
      port_q       <= MARB_PORT_FETCH;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Combinational accept and memory drive are forced quiet while reset is held.
  assign bus.req_ready = rst ? 2'b00 : req_ready_s;
  assign bus.mem_raddr = rst ? {ADDR_W{1'b0}} : mem_raddr_s;
  assign bus.mem_waddr = rst ? {ADDR_W{1'b0}} : mem_waddr_s;
  assign bus.mem_wdata = rst ? {DATA_W{1'b0}} : mem_wdata_s;
  assign bus.mem_wen   = rst ? 1'b0 : mem_wen_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != MARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a round-robin and a fixed-priority
// instance, each with its own memory, checked against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [1:0]  pv;
  logic [1:0]  pwe;
  logic [31:0] pa0, pa1, pwd;
  logic [1:0]  refill;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  logic [31:0] env_mem0 [256];
  logic [31:0] env_mem1 [256];
  logic [31:0] ref_mem  [2][256];

  int          checks;
  int          failures;
  int          busy_cnt;
  logic        last_g;
  logic        infl_port;
  logic [31:0] infl_addr;
  logic [31:0] infl_exp;
  int          grant_log[$];
  int          wen_cycles;
  int          rsp_seen;
  logic [31:0] seen_rsp;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .clk (clk), .rst (rst), .bus (bus_rr)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk (clk), .rst (rst), .bus (bus_fp)
  );

  assign bus_rr.req_valid  = sel ? 2'b00 : pv;
  assign bus_rr.req_we     = pwe;
  assign bus_rr.req_addr0  = pa0;
  assign bus_rr.req_addr1  = pa1;
  assign bus_rr.req_wdata1 = pwd;
  assign bus_fp.req_valid  = sel ? pv : 2'b00;
  assign bus_fp.req_we     = pwe;
  assign bus_fp.req_addr0  = pa0;
  assign bus_fp.req_addr1  = pa1;
  assign bus_fp.req_wdata1 = pwd;

  logic [1:0]  o_ready, o_rsp_valid;
  logic [31:0] o_rsp_data, o_raddr, o_waddr, o_wdata;
  logic        o_wen, o_busy;
  assign o_ready     = sel ? bus_fp.req_ready : bus_rr.req_ready;
  assign o_rsp_valid = sel ? bus_fp.rsp_valid : bus_rr.rsp_valid;
  assign o_rsp_data  = sel ? bus_fp.rsp_data  : bus_rr.rsp_data;
  assign o_raddr     = sel ? bus_fp.mem_raddr : bus_rr.mem_raddr;
  assign o_waddr     = sel ? bus_fp.mem_waddr : bus_rr.mem_waddr;
  assign o_wdata     = sel ? bus_fp.mem_wdata : bus_rr.mem_wdata;
  assign o_wen       = sel ? bus_fp.mem_wen   : bus_rr.mem_wen;
  assign o_busy      = sel ? bus_fp.busy      : bus_rr.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory behind each instance.
  always @(posedge clk) begin
    if (pre_we) env_mem0[pre_addr] <= pre_data;
    else if (bus_rr.mem_wen) env_mem0[bus_rr.mem_waddr[7:0]] <= bus_rr.mem_wdata;
    bus_rr.mem_rdata <= env_mem0[bus_rr.mem_raddr[7:0]];
  end

  always @(posedge clk) begin
    if (pre_we) env_mem1[pre_addr] <= pre_data;
    else if (bus_fp.mem_wen) env_mem1[bus_fp.mem_waddr[7:0]] <= bus_fp.mem_wdata;
    bus_fp.mem_rdata <= env_mem1[bus_fp.mem_raddr[7:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int p);
    if (p == 1) begin
      pv[1]  = 1'b1;
      pa1    = 32'($urandom_range(0, 255));
      pwe[1] = 1'($urandom_range(0, 1));
      pwd    = $urandom;
    end else begin
      pv[0]  = 1'b1;
      pa0    = 32'($urandom_range(0, 255));
      pwe[0] = 1'b0;
    end
  endtask

  function automatic int port0_grants();
    int n = 0;
    foreach (grant_log[i]) if (grant_log[i] == 0) n++;
    return n;
  endfunction

  // One clock of the transaction model; entered and left at posedge+2.
  task automatic cycle();
    logic        g_ok, g, acc_w, acc_r;
    logic [31:0] g_addr;
    #1;
    g_ok   = (busy_cnt == 0) && (pv != 2'b00);
    g      = (pv == 2'b11) ? ((sel == 1'b0) ? ~last_g : 1'b1) : pv[1];
    g_addr = g ? pa1 : pa0;
    acc_w  = g_ok && pwe[g];
    acc_r  = g_ok && !pwe[g];
    check("req_ready", o_ready, g_ok ? (g ? 2'b10 : 2'b01) : 2'b00);
    check("busy", o_busy, busy_cnt != 0);
    check("rsp_valid", o_rsp_valid, (busy_cnt == 1) ? (infl_port ? 2'b10 : 2'b01) : 2'b00);
    if (busy_cnt == 1) check("rsp_data", o_rsp_data, infl_exp);
    check("mem_wen", o_wen, acc_w);
    check("mem_waddr", o_waddr, acc_w ? g_addr : 32'h0);
    check("mem_wdata", o_wdata, acc_w ? pwd : 32'h0);
    check("mem_raddr", o_raddr, acc_r ? g_addr : ((busy_cnt == 2) ? infl_addr : 32'h0));
    if (o_wen) wen_cycles++;
    if (o_rsp_valid != 2'b00) begin
      rsp_seen++;
      seen_rsp = o_rsp_data;
    end
    if (busy_cnt > 0) busy_cnt--;
    if (g_ok) begin
      busy_cnt  = 2;
      last_g    = g;
      infl_port = g;
      infl_addr = g_addr;
      grant_log.push_back(int'(g));
      if (acc_w) begin
        ref_mem[sel][g_addr[7:0]] = pwd;
        infl_exp = 32'h0;
      end else begin
        infl_exp = ref_mem[sel][g_addr[7:0]];
      end
    end
    @(posedge clk);
    #2;
    if (g_ok) begin
      if (refill[g]) new_req(int'(g));
      else pv[g] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_req_ready", o_ready, 2'b00);
    check("rst_rsp_valid", o_rsp_valid, 2'b00);
    check("rst_rsp_data", o_rsp_data, 32'h0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_mem_wen", o_wen, 1'b0);
    check("rst_mem_raddr", o_raddr, 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    busy_cnt = 0;
    last_g   = 1'b1;
    #1;
  endtask

  initial begin
    int n, c0, g0, w0;
    checks = 0; failures = 0; busy_cnt = 0; last_g = 1'b1;
    infl_port = 1'b0; infl_addr = 32'h0; infl_exp = 32'h0;
    wen_cycles = 0; rsp_seen = 0; seen_rsp = 32'h0;
    rst = 1'b1; sel = 1'b0; pv = 2'b00; pwe = 2'b00;
    pa0 = 32'h0; pa1 = 32'h0; pwd = 32'h0; refill = 2'b00;
    pre_we = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;

    @(posedge clk);
    #2;
    pre_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i);
      pre_data = (i == 16) ? 32'hDEADBEEF : $urandom;
      ref_mem[0][i] = pre_data;
      ref_mem[1][i] = pre_data;
      @(posedge clk);
      #2;
    end
    pre_we = 1'b0;
    apply_reset();

    // Port 0 read of the preloaded word.
    pv[0] = 1'b1; pwe[0] = 1'b0; pa0 = 32'h10;
    c0 = rsp_seen;
    repeat (4) cycle();
    check("t1_rsp_pulses", rsp_seen - c0, 1);
    check("t1_rsp_data", seen_rsp, 32'hDEADBEEF);

    // Port 1 write, then read it back through port 0.
    pv[1] = 1'b1; pwe[1] = 1'b1; pa1 = 32'h20; pwd = 32'h12345678;
    w0 = wen_cycles;
    repeat (4) cycle();
    check("t2_wen_cycles", wen_cycles - w0, 1);
    check("t2_write_rsp_data", seen_rsp, 32'h0);
    pv[0] = 1'b1; pa0 = 32'h20;
    repeat (4) cycle();
    check("t2_readback", seen_rsp, 32'h12345678);

    // Round-robin under continuous contention.
    apply_reset();
    grant_log.delete();
    refill = 2'b11; new_req(0); new_req(1);
    n = 0;
    while (grant_log.size() < 6 && n < 40) begin cycle(); n++; end
    refill = 2'b00; pv = 2'b00;
    repeat (3) cycle();
    check("t3_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("t3_grant_order", grant_log[i], i % 2);

    // Fixed priority: data port wins until it stops requesting.
    sel = 1'b1;
    apply_reset();
    grant_log.delete();
    refill = 2'b11; new_req(0); new_req(1);
    n = 0;
    while (grant_log.size() < 6 && n < 40) begin cycle(); n++; end
    check("t4_port0_starved", port0_grants(), 0);
    refill[1] = 1'b0;
    n = 0;
    while (port0_grants() == 0 && n < 20) begin cycle(); n++; end
    check("t4_port0_granted", port0_grants() > 0, 1'b1);
    refill = 2'b00; pv = 2'b00;
    repeat (3) cycle();

    // Reset during ACCESS of a read abandons it; the next request is served.
    sel = 1'b0;
    apply_reset();
    pv[0] = 1'b1; pa0 = 32'h10;
    cycle();
    pv[0] = 1'b1; pa0 = 32'h40;
    c0 = rsp_seen; g0 = grant_log.size();
    apply_reset();
    repeat (5) cycle();
    check("t5_rsp_after_reset", rsp_seen - c0, 1);
    check("t5_grants_after_reset", grant_log.size() - g0, 1);
    check("t5_rsp_data", seen_rsp, ref_mem[0][8'h40]);

    // Port 0 withdraws while port 1 is in flight.
    pv[1] = 1'b1; pwe[1] = 1'b1; pa1 = 32'h50; pwd = $urandom;
    cycle();
    g0 = port0_grants(); c0 = rsp_seen;
    pv[0] = 1'b1; pa0 = 32'h60;
    repeat (2) cycle();
    pv[0] = 1'b0;
    repeat (2) cycle();
    check("t6_no_port0_grant", port0_grants() - g0, 0);
    check("t6_one_response", rsp_seen - c0, 1);
    check("t6_idle_busy", o_busy, 1'b0);

    // Random traffic with legal withdrawals on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      apply_reset();
      for (int k = 0; k < 300; k++) begin
        cycle();
        for (int p = 0; p < 2; p++) begin
          if (!pv[p]) begin
            if ($urandom_range(0, 2) == 0) new_req(p);
          end else if ($urandom_range(0, 9) == 0) begin
            pv[p] = 1'b0;
          end
        end
      end
      pv = 2'b00;
      repeat (3) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported main_memory between two requesters: instruction fetch (port 0) and data load/store (port 1).
- Each port uses a valid/ready request handshake and gets a one-cycle response pulse.
- The block sits between the fetch/execute sequencing logic and main_memory, replacing direct stage-based address muxing.
- Ownership of the memory port becomes explicit, so a stalled requester waits instead of being silently overridden.

Parameters:
ADDR_W, 32, width of request and memory addresses
DATA_W, 32, width of write data, read data and response data
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with data port (1) winning

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  2  per-port request valid; bit0 fetch, bit1 data
req_ready  output  2  per-port accept; at most one bit high
req_we  input  2  per-port write flag (fetch drives 0)
req_addr0  input  ADDR_W  port 0 address
req_addr1  input  ADDR_W  port 1 address
req_wdata1  input  DATA_W  port 1 write data
rsp_valid  output  2  per-port one-cycle completion pulse
rsp_data  output  DATA_W  read data of the completing transaction; 0 for writes
mem_raddr  output  ADDR_W  main_memory read address
mem_waddr  output  ADDR_W  main_memory write address
mem_wdata  output  DATA_W  main_memory write data
mem_wen  output  1  main_memory write enable
mem_rdata  input  DATA_W  main_memory read data, valid one cycle after mem_raddr is presented
busy  output  1  high while a transaction is in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, mem_wen = 0, busy = 0.
  - Held address/data/port/we registers = 0.
- States:
  - IDLE: arbitrate.
  - ACCESS: memory read in progress.
  - RESP: drive the response.
- IDLE:
  - With no req_valid bit set, stay in IDLE; all req_ready = 0.
  - With a single requester, grant it.
  - With both requesting and RR_EN=1, grant the port != last_grant. With RR_EN=0, grant port 1.
  - req_ready[winner] = 1 combinationally in the same cycle; the handshake completes this cycle (cycle T).
  - In cycle T, latch addr, we, wdata and port; update last_grant; go to ACCESS.
- Memory drive in cycle T:
  - Read: mem_raddr = winner address.
  - Write: mem_wen = 1, mem_waddr = addr, mem_wdata = wdata.
  - mem_wen is high only in the accept cycle; it is never high in ACCESS or RESP.
- ACCESS (T+1):
  - mem_raddr holds the latched address.
  - Capture mem_rdata into rsp_data for reads, or 0 for writes.
  - Go to RESP.
- RESP (T+2):
  - rsp_valid[latched port] = 1 for exactly one cycle; rsp_data stable that cycle.
  - Go to IDLE.
  - No arbitration happens in RESP; req_ready = 0.
- Timing:
  - Latency is request accept to rsp_valid = 2 cycles.
  - Throughput is at most one transaction per 3 cycles.
- Requester rules:
  - A requester must hold req_valid, addr and wdata stable until req_ready.
  - The arbiter must not drop an un-accepted request.
  - Deasserting req_valid before accept withdraws it legally.
- Starvation: with RR_EN=1 and both ports continuously valid, grants strictly alternate 0,1,0,1.
- Outside the accept cycle and ACCESS: mem_raddr = 0, mem_waddr = 0, mem_wdata = 0.
- Reset mid-transaction: the in-flight transaction is abandoned and no rsp_valid is emitted. Memory side effects already issued (a write in cycle T) are not undone.
- Widths: no arithmetic; addresses pass through unmodified. rsp_data is zero-extended from mem_rdata when widths match.

Decomposition:
- arch_defines holds:
  - the state encodings (MARB_IDLE, MARB_ACCESS, MARB_RESP, 2-bit `MARB_STATE_WIDTH);
  - the port indices (MARB_PORT_FETCH = 0, MARB_PORT_DATA = 1).
- Sub-module rr_arbiter2: purely combinational 2-way grant from req_valid, last_grant and RR_EN. The FSM, holding registers and memory muxing stay in mem_port_arbiter.

Test Plan:
- Reset then port 0 read of addr 0x10, memory preloaded 0xDEADBEEF → req_ready[0] in the same cycle, mem_raddr = 0x10, rsp_valid[0] two cycles later with rsp_data = 0xDEADBEEF.
- Port 1 write addr 0x20, data 0x12345678 → mem_wen = 1 for exactly one cycle with matching waddr/wdata, rsp_valid[1] at T+2 with rsp_data = 0. A subsequent port 0 read of 0x20 returns 0x12345678.
- Both ports valid continuously for 6 transactions with RR_EN=1 → grant order 0,1,0,1,0,1; each rsp_valid is one cycle; busy is low only on accept cycles.
- Same stimulus with RR_EN=0 → port 1 granted every time; port 0 never granted until port 1 drops valid.
- rst asserted in ACCESS state of a read → outputs zero asynchronously, no rsp_valid after release; the next request is accepted normally.
- Port 0 valid for 2 cycles then withdrawn while a port 1 transaction is in flight → no grant or response for port 0; arbiter returns to IDLE with busy = 0.
